// File: rtl/mdu_pkg.sv
// Shared constants and enumerations for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int ITERS  = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Divide and remainder share the restoring-division iteration.
    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 8-bit unsigned multiply / divide unit writing into a register file.
// One shared datapath: a 16-bit accumulator (product, or remainder in its low
// byte), an 8-bit shift register (multiplier, or dividend turning into the
// quotient) and a single 9-bit adder/subtractor. Eight iterations per op.
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [DATA_W-1:0]   rs1_data,
    input  logic [DATA_W-1:0]   rs2_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                busy,
    output logic                done,
    output logic                we3,
    output logic [ADDR_W-1:0]   wa3,
    output logic [DATA_W-1:0]   wd3
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    op_e                    op_q, op_d;
    logic [ADDR_W-1:0]      rd_q, rd_d;
    logic [DATA_W-1:0]      opb_q, opb_d;
    logic [2*DATA_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic [DATA_W-1:0]      res_q, res_d;

    logic [DATA_W:0]        alu_a;
    logic [DATA_W:0]        alu_b;
    logic                   alu_sub;
    logic [DATA_W+1:0]      alu_y;
    logic [2*DATA_W-1:0]    acc_iter;
    logic [DATA_W-1:0]      sh_iter;
    logic [DATA_W-1:0]      iter_res;

    // One iteration of shift-add multiply or restoring divide on the shared adder.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_sub  = 1'b0;
        acc_iter = acc_q;
        sh_iter  = sh_q;
        if (is_div_op(op_q)) begin
            // Shift the next dividend bit into the partial remainder and try
            // to subtract the divisor; the borrow decides the quotient bit.
            alu_a   = {acc_q[DATA_W-1:0], sh_q[DATA_W-1]};
            alu_b   = {1'b0, opb_q};
            alu_sub = 1'b1;
        end else begin
            // Add the multiplicand into the high half when the multiplier LSB is set.
            alu_a   = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
            alu_b   = sh_q[0] ? {1'b0, opb_q} : '0;
        end
        alu_y = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b})
                        : ({1'b0, alu_a} + {1'b0, alu_b});
        if (is_div_op(op_q)) begin
            // A zero divisor never borrows, giving an all-ones quotient and the
            // dividend as remainder without any special casing.
            if (alu_y[DATA_W+1]) begin
                acc_iter = {{DATA_W{1'b0}}, alu_a[DATA_W-1:0]};
                sh_iter  = {sh_q[DATA_W-2:0], 1'b0};
            end else begin
                acc_iter = {{DATA_W{1'b0}}, alu_y[DATA_W-1:0]};
                sh_iter  = {sh_q[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_iter = {alu_y[DATA_W:0], acc_q[DATA_W-1:1]};
            sh_iter  = {1'b0, sh_q[DATA_W-1:1]};
        end
        unique case (op_q)
            OP_MUL:  iter_res = acc_iter[DATA_W-1:0];
            OP_MULH: iter_res = acc_iter[2*DATA_W-1:DATA_W];
            OP_DIV:  iter_res = sh_iter;
            default: iter_res = acc_iter[DATA_W-1:0];
        endcase
    end

    // Next-state logic, operand capture and DONE-cycle register-file write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        res_d   = res_q;
        busy    = 1'b0;
        done    = 1'b0;
        we3     = 1'b0;
        wa3     = '0;
        wd3     = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    rd_d    = rd_addr;
                    opb_d   = rs2_data;
                    acc_d   = '0;
                    sh_d    = rs1_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                acc_d = acc_iter;
                sh_d  = sh_iter;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    res_d   = iter_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                we3     = (rd_q != '0);
                wa3     = rd_q;
                wd3     = res_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            rd_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit with a register-file model.
module tb_mul_div_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] rs1_data;
    logic [7:0] rs2_data;
    logic [2:0] rd_addr;
    logic       busy;
    logic       done;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;

    typedef struct packed {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] rf [8];
    logic [7:0] rf_model [8];
    logic [2:0] ra;
    logic [7:0] rd1;
    int         n_checks = 0;
    int         n_fail   = 0;

    mul_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered register file fed by the write port; read port rd1.
    initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    always @(posedge clk) if (we3) rf[wa3] <= wd3;
    assign rd1 = rf[ra];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: on every DONE cycle pop the scoreboard, otherwise outputs must be idle.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got wa3=%0d we3=%0d wd3=%h, expected no done", wa3, we3, wd3);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("done_write{we3,wa3,wd3}", {20'h0, we3, wa3, wd3}, {20'h0, e.we, e.wa, e.wd});
            end
        end else begin
            check("idle_outputs{we3,wa3,wd3}", {20'h0, we3, wa3, wd3}, 32'h0);
        end
    end

    task automatic push_exp(input logic [2:0] rd, input logic [7:0] exp);
        wr_t e;
        e.we = (rd != 3'd0);
        e.wa = rd;
        e.wd = exp;
        sb_q.push_back(e);
        if (rd != 3'd0) rf_model[rd] = exp;
    endtask

    // Counts edges (latch edge = 1) until done is seen; optionally re-pulses start mid-RUN.
    task automatic wait_done(input int glitch_at, input bit hold, output int edges);
        edges = 1;
        forever begin
            @(negedge clk);
            if (done || edges >= 20) break;
            if (edges == glitch_at) begin
                start = 1'b1; op = 2'b00; rs1_data = 8'h01; rs2_data = 8'h01; rd_addr = 3'd6;
            end
            @(posedge clk);
            edges++;
            #1;
            if (!hold) start = 1'b0;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d edges, expected done", edges);
        end
    endtask

    task automatic readback(input logic [2:0] addr);
        ra = addr;
        #1;
        check($sformatf("rf_readback_r%0d", addr), {24'h0, rd1}, {24'h0, rf_model[addr]});
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] rd, input logic [7:0] exp, input int glitch_at);
        int edges;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        push_exp(rd, exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands are free to change once latched.
        op = 2'($urandom); rs1_data = 8'($urandom); rs2_data = 8'($urandom); rd_addr = 3'($urandom);
        wait_done(glitch_at, 1'b0, edges);
        check("latency_edges", edges, 9);
        @(posedge clk);
        #1;
        readback(rd);
    endtask

    initial begin
        int edges;
        for (int i = 0; i < 8; i++) rf_model[i] = 8'h00;
        rst = 1'b0; start = 1'b0; op = 2'b00; rs1_data = 8'h00; rs2_data = 8'h00; rd_addr = 3'd0; ra = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs{busy,done,we3,wa3,wd3}", {19'h0, busy, done, we3, wa3, wd3}, 32'h0);
        rst = 1'b1;

        run_op(2'b00, 8'h0D, 8'h0B, 3'd1, 8'h8F, -1);   // MUL
        run_op(2'b01, 8'h0D, 8'h0B, 3'd1, 8'h00, -1);   // MULH
        run_op(2'b00, 8'hFF, 8'hFF, 3'd7, 8'h01, -1);   // MUL
        run_op(2'b01, 8'hFF, 8'hFF, 3'd7, 8'hFE, -1);   // MULH
        run_op(2'b10, 8'hC8, 8'h07, 3'd2, 8'h1C, -1);   // DIV
        run_op(2'b11, 8'hC8, 8'h07, 3'd3, 8'h04, -1);   // REM
        run_op(2'b10, 8'h34, 8'h00, 3'd4, 8'hFF, -1);   // DIV by zero
        run_op(2'b11, 8'h34, 8'h00, 3'd5, 8'h34, -1);   // REM by zero
        run_op(2'b10, 8'hC8, 8'h07, 3'd5, 8'h1C, 3);    // start re-pulsed mid-RUN
        run_op(2'b00, 8'h0D, 8'h0B, 3'd0, 8'h8F, -1);   // rd_addr 0: no write

        // start held high through DONE is taken at the first IDLE edge.
        @(negedge clk);
        op = 2'b00; rs1_data = 8'h03; rs2_data = 8'h05; rd_addr = 3'd6; start = 1'b1;
        push_exp(3'd6, 8'h0F);
        @(posedge clk);
        #1;
        wait_done(-1, 1'b1, edges);
        check("hold_latency_edges", edges, 9);
        op = 2'b00; rs1_data = 8'h02; rs2_data = 8'h07; rd_addr = 3'd1;
        push_exp(3'd1, 8'h0E);
        @(posedge clk);
        #1;
        check("hold_busy_idle", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        check("hold_busy_accept", {31'h0, busy}, 32'h1);
        start = 1'b0;
        wait_done(-1, 1'b0, edges);
        check("hold_second_latency", edges, 9);
        @(posedge clk);
        #1;
        readback(3'd6);
        readback(3'd1);

        // Reset in the middle of RUN aborts with no write.
        @(negedge clk);
        op = 2'b10; rs1_data = 8'h50; rs2_data = 8'h03; rd_addr = 3'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_outputs{busy,done,we3,wa3,wd3}", {19'h0, busy, done, we3, wa3, wd3}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        readback(3'd7);

        run_op(2'b11, 8'h50, 8'h03, 3'd7, 8'h02, -1);   // REM after reset

        for (int i = 0; i < 8; i++) readback(3'(i));
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
